// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - 64-bit data memory with fixed-latency request/response handshake
// Optional feature macro: DATAMEM_MISALIGN_TRAP_EN (misaligned accesses trap via oError).
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [63:0] iAddress,
  input  logic [63:0] iWriteData,
  output logic [63:0] oReadData,
  output logic        oReady,
  output logic        oBusy
`ifdef DATAMEM_MISALIGN_TRAP_EN
  ,
  output logic        oError
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [AW-1:0] reqIdx;
  logic [63:0] reqData;
  logic        reqWrite;
  logic [63:0] mem [DEPTH_WORDS];

  logic          req;
  logic          enterDone;
  logic [AW-1:0] selIdx;
  logic [63:0]   selData;
  logic          selWrite;
  logic          trap;

`ifdef DATAMEM_MISALIGN_TRAP_EN
  logic reqMis;
  logic unusedAddr;
  assign unusedAddr = ^iAddress[63:AW+3];
`else
  logic unusedAddr;
  assign unusedAddr = ^{iAddress[63:AW+3], iAddress[2:0]};
`endif

  assign req = iMemRead | iMemWrite;

  // With LATENCY=1 the acceptance edge is also the DONE edge, so act on live inputs.
  always_comb begin
    enterDone = 1'b0;
    selIdx    = reqIdx;
    selData   = reqData;
    selWrite  = reqWrite;
    trap      = 1'b0;
    if (LATENCY == 1) begin
      enterDone = (state == IDLE) && req;
      selIdx    = iAddress[AW+2:3];
      selData   = iWriteData;
      selWrite  = iMemWrite;
`ifdef DATAMEM_MISALIGN_TRAP_EN
      trap      = |iAddress[2:0];
`endif
    end else begin
      enterDone = (state == WAIT) && (cnt == 4'd0);
`ifdef DATAMEM_MISALIGN_TRAP_EN
      trap      = reqMis;
`endif
    end
  end

  // Storage survives reset; the iRST gate keeps a write from landing on a reset edge.
  always_ff @(posedge iCLK) begin
    if (enterDone && selWrite && !trap && !iRST) begin
      mem[selIdx] <= selData;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      reqIdx    <= '0;
      reqData   <= 64'd0;
      reqWrite  <= 1'b0;
      oReady    <= 1'b0;
      oBusy     <= 1'b0;
      oReadData <= 64'd0;
`ifdef DATAMEM_MISALIGN_TRAP_EN
      reqMis    <= 1'b0;
      oError    <= 1'b0;
`endif
    end else begin
      oReady <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            reqIdx   <= iAddress[AW+2:3];
            reqData  <= iWriteData;
            reqWrite <= iMemWrite;
`ifdef DATAMEM_MISALIGN_TRAP_EN
            reqMis   <= |iAddress[2:0];
`endif
            oBusy    <= 1'b1;
            if (LATENCY == 1) begin
              state  <= DONE;
              oReady <= 1'b1;
            end else begin
              state  <= WAIT;
              cnt    <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state  <= DONE;
            oReady <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
      endcase
      if (enterDone && !selWrite && !trap) begin
        oReadData <= mem[selIdx];
      end
`ifdef DATAMEM_MISALIGN_TRAP_EN
      oError <= enterDone && trap;
`endif
    end
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, SHALL set the number of 64-bit storage words (power of two, 2..4096).
REQ-002 Parameter LATENCY, default 2, SHALL set the acceptance-to-response delay in clock cycles (1..15).
REQ-003 iCLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 iRST  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 iMemRead  input  1  SHALL be the read request from the datapath.
REQ-006 iMemWrite  input  1  SHALL be the write request from the datapath.
REQ-007 iAddress  input  64  SHALL be the byte address; word index = iAddress[log2(DEPTH_WORDS)+2:3].
REQ-008 iWriteData  input  64  SHALL be the write data.
REQ-009 oReadData  output  64  SHALL be the registered read data.
REQ-010 oReady  output  1  SHALL pulse for one cycle when a request completes.
REQ-011 oBusy  output  1  SHALL be high whenever a request is in flight (state not IDLE).
REQ-012 oError  output  1  SHALL exist only when DATAMEM_MISALIGN_TRAP_EN is defined.

Function
REQ-013 FSM states SHALL be IDLE, WAIT and DONE.
REQ-014 In IDLE, a rising edge with iMemRead or iMemWrite high SHALL accept the request and capture address, data and type.
REQ-015 If LATENCY=1, acceptance SHALL go IDLE->DONE; otherwise it SHALL go IDLE->WAIT, with WAIT lasting exactly LATENCY-1 cycles under a down-counter.
REQ-016 oReady SHALL be high only in DONE, i.e. in the cycle after the LATENCY-th rising edge following acceptance.
REQ-017 DONE SHALL always return to IDLE on the next edge; minimum request-to-request period SHALL be LATENCY+1 cycles.
REQ-018 Requests presented in WAIT or DONE SHALL be ignored, not queued; the requester must hold or re-present them in IDLE.
REQ-019 A write SHALL commit to storage on the edge entering DONE; oReadData SHALL be unchanged by a write.
REQ-020 A read SHALL load oReadData on the edge entering DONE; oReadData SHALL hold that value until the next completed read.
REQ-021 iMemRead and iMemWrite both high at acceptance SHALL be treated as a write.
REQ-022 Word-index bits above the storage range SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*8 bytes.
REQ-023 Inputs changing after acceptance SHALL NOT affect the in-flight request.

Reset
REQ-024 iRST SHALL immediately force state IDLE, counter 0, oReady 0, oBusy 0, oReadData 0 and oError 0.
REQ-025 Reset mid-operation SHALL abort the request; an aborted write SHALL NOT commit.
REQ-026 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-027 With DATAMEM_MISALIGN_TRAP_EN defined, a request accepted with iAddress[2:0] != 0 SHALL complete with normal timing, perform no write, leave oReadData unchanged, and assert oError together with oReady.
REQ-028 Without DATAMEM_MISALIGN_TRAP_EN, the oError port SHALL be absent, iAddress[2:0] SHALL be ignored, and misaligned accesses SHALL act on the containing word.

Verification
REQ-029 Scenario 1: with LATENCY=2, write 0xDEADBEEFCAFEF00D to 0x40, then read 0x40 -> oReady goes high 2 cycles after each acceptance and oReadData = 0xDEADBEEFCAFEF00D.
REQ-030 Scenario 2: with iMemRead held high continuously -> accepted reads occur every 3 cycles (LATENCY+1), and oBusy is high on 2 of every 3 cycles.
REQ-031 Scenario 3: with DEPTH_WORDS=256, write 0x1 to 0x800 (address 2048), then read 0x0 -> oReadData = 0x1 (wrap-around).
REQ-032 Scenario 4: accept a write of 0x55 to 0x10 (old content 0xAA), then assert iRST in WAIT -> outputs are 0, and a later read of 0x10 returns 0xAA.
REQ-033 Scenario 5: accept a request with iMemRead=iMemWrite=1 and data 0x7 at 0x18 -> the write commits and oReadData keeps its previous value.
REQ-034 Scenario 6 (macro defined): write to 0x13 -> oError=1 and oReady=1 for one cycle, and the word at 0x10 is unchanged.
